// File: rtl/svo_tmds_dec.sv
// Single-channel TMDS receive decoder: finds symbol alignment by bitslipping until
// a run of control tokens is seen, then decodes DE / control / pixel data.
module svo_tmds_dec #(
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int SLIP_WAIT      = 16,
  parameter int LOCK_TOKENS    = 8,
  parameter int LOSS_TIMEOUT   = 65536
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [9:0] din,
  output logic       bitslip,
  output logic       locked,
  output logic       de,
  output logic [1:0] ctrl,
  output logic [7:0] dout
);

  localparam int SCW = $clog2(SEARCH_TIMEOUT + 1);
  localparam int WCW = $clog2(SLIP_WAIT + 1);
  localparam int TCW = $clog2(LOCK_TOKENS + 1);
  localparam int LCW = $clog2(LOSS_TIMEOUT + 1);

  localparam logic [SCW-1:0] SCNT_LAST = SCW'(SEARCH_TIMEOUT - 1);
  localparam logic [WCW-1:0] WCNT_LAST = WCW'(SLIP_WAIT - 1);
  localparam logic [TCW-1:0] TCNT_LAST = TCW'(LOCK_TOKENS - 1);
  localparam logic [LCW-1:0] LCNT_LAST = LCW'(LOSS_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_SLIP_WAIT,
    ST_CONFIRM,
    ST_LOCKED
  } state_t;

  state_t         state_q, state_d;
  logic [SCW-1:0] scnt_q, scnt_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic [LCW-1:0] lcnt_q, lcnt_d;

  logic [9:0] din_q;
  logic       tok;
  logic [1:0] tok_ctrl;
  logic [7:0] q_byte;
  logic [7:0] dec_byte;

  logic       bitslip_q, bitslip_d;
  logic       locked_q, locked_d;
  logic       de_q, de_d;
  logic [1:0] ctrl_q, ctrl_d;
  logic [7:0] dout_q, dout_d;

  always_comb begin
    tok      = 1'b1;
    tok_ctrl = 2'b00;
    case (din_q)
      10'h354: tok_ctrl = 2'b00;
      10'h0AB: tok_ctrl = 2'b01;
      10'h154: tok_ctrl = 2'b10;
      10'h2AB: tok_ctrl = 2'b11;
      default: tok = 1'b0;
    endcase
  end

  // Inverse of the encoder's XOR/XNOR transition chain.
  always_comb begin
    q_byte      = din_q[9] ? ~din_q[7:0] : din_q[7:0];
    dec_byte    = 8'h00;
    dec_byte[0] = q_byte[0];
    for (int i = 1; i < 8; i++) begin
      dec_byte[i] = din_q[8] ? (q_byte[i] ^ q_byte[i-1]) : ~(q_byte[i] ^ q_byte[i-1]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_SEARCH;
      scnt_q  <= '0;
      wcnt_q  <= '0;
      tcnt_q  <= '0;
      lcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
      lcnt_q  <= lcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    wcnt_d  = wcnt_q;
    tcnt_d  = tcnt_q;
    lcnt_d  = lcnt_q;
    case (state_q)
      ST_SEARCH: begin
        scnt_d = scnt_q + 1'b1;
        if (tok) begin
          if (LOCK_TOKENS == 1) begin
            state_d = ST_LOCKED;
            scnt_d  = '0;
            tcnt_d  = '0;
            lcnt_d  = '0;
          end else begin
            state_d = ST_CONFIRM;
            tcnt_d  = TCW'(1);
          end
        end else if (scnt_q >= SCNT_LAST) begin
          state_d = ST_SLIP_WAIT;
          scnt_d  = '0;
        end
      end
      ST_SLIP_WAIT: begin
        if (wcnt_q == WCNT_LAST) begin
          state_d = ST_SEARCH;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      // A token that lands on the timeout cycle still loses to the slip.
      ST_CONFIRM: begin
        scnt_d = scnt_q + 1'b1;
        if (scnt_q >= SCNT_LAST) begin
          state_d = ST_SLIP_WAIT;
          scnt_d  = '0;
          tcnt_d  = '0;
        end else if (tok) begin
          if (tcnt_q == TCNT_LAST) begin
            state_d = ST_LOCKED;
            scnt_d  = '0;
            tcnt_d  = '0;
            lcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end else begin
          state_d = ST_SEARCH;
          tcnt_d  = '0;
        end
      end
      ST_LOCKED: begin
        if (tok) begin
          lcnt_d = '0;
        end else if (lcnt_q == LCNT_LAST) begin
          state_d = ST_SEARCH;
          scnt_d  = '0;
          tcnt_d  = '0;
          lcnt_d  = '0;
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  // Outputs are gated by the next state so they register on the same edge as locked.
  always_comb begin
    bitslip_d = (state_q != ST_SLIP_WAIT) && (state_d == ST_SLIP_WAIT);
    locked_d  = (state_d == ST_LOCKED);
    de_d      = 1'b0;
    ctrl_d    = 2'b00;
    dout_d    = 8'h00;
    if (locked_d) begin
      if (tok) begin
        ctrl_d = tok_ctrl;
      end else begin
        de_d   = 1'b1;
        ctrl_d = ctrl_q;
        dout_d = dec_byte;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      din_q     <= '0;
      bitslip_q <= 1'b0;
      locked_q  <= 1'b0;
      de_q      <= 1'b0;
      ctrl_q    <= 2'b00;
      dout_q    <= 8'h00;
    end else begin
      din_q     <= din;
      bitslip_q <= bitslip_d;
      locked_q  <= locked_d;
      de_q      <= de_d;
      ctrl_q    <= ctrl_d;
      dout_q    <= dout_d;
    end
  end

  assign bitslip = bitslip_q;
  assign locked  = locked_q;
  assign de      = de_q;
  assign ctrl    = ctrl_q;
  assign dout    = dout_q;

endmodule

// File: tb/tb_svo_tmds_dec.sv
// Directed bench for svo_tmds_dec: alignment, token map, data decode, confirm break,
// loss of lock, misalignment recovery and asynchronous reset.
module tb_svo_tmds_dec;

  localparam int ST = 64;
  localparam int SW = 4;
  localparam int LT = 8;
  localparam int LO = 32;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [9:0] din = 10'h100;
  logic       bitslip;
  logic       locked;
  logic       de;
  logic [1:0] ctrl;
  logic [7:0] dout;

  int checks = 0;
  int failures = 0;

  svo_tmds_dec #(
    .SEARCH_TIMEOUT(ST),
    .SLIP_WAIT(SW),
    .LOCK_TOKENS(LT),
    .LOSS_TIMEOUT(LO)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .din(din),
    .bitslip(bitslip),
    .locked(locked),
    .de(de),
    .ctrl(ctrl),
    .dout(dout)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] rotl10(input logic [9:0] x, input int r);
    logic [9:0] y;
    y = x;
    for (int i = 0; i < r; i++) y = {y[8:0], y[9]};
    return y;
  endfunction

  // Called at a negedge: drive a symbol, cross one rising edge, return at the next negedge.
  task automatic step(input logic [9:0] sym);
    din = sym;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    resetn = 1'b0;
    din = 10'h100;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 1'b0;
    din = 10'h354;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bitslip !== 1'b0) begin failures++; $display("[TB] FAIL reset_bitslip: got %b expected 0", bitslip); end
    checks++; if (locked !== 1'b0) begin failures++; $display("[TB] FAIL reset_locked: got %b expected 0", locked); end
    checks++; if (de !== 1'b0) begin failures++; $display("[TB] FAIL reset_de: got %b expected 0", de); end
    checks++; if (ctrl !== 2'b00) begin failures++; $display("[TB] FAIL reset_ctrl: got %b expected 00", ctrl); end
    checks++; if (dout !== 8'h00) begin failures++; $display("[TB] FAIL reset_dout: got %h expected 00", dout); end
    resetn = 1'b1;
  endtask

  task automatic test_aligned();
    int lockCycle;
    lockCycle = 0;
    for (int k = 1; k <= 12; k++) begin
      step(10'h354);
      checks++; if (bitslip !== 1'b0) begin failures++; $display("[TB] FAIL aligned_bitslip cycle %0d: got %b expected 0", k, bitslip); end
      if (locked === 1'b1 && lockCycle == 0) lockCycle = k;
    end
    checks++;
    if (lockCycle < LT || lockCycle > 12) begin
      failures++; $display("[TB] FAIL aligned_lock_cycle: got %0d expected within %0d..12", lockCycle, LT);
    end
    for (int k = 0; k < 4; k++) begin
      step(10'h354);
      checks++; if (locked !== 1'b1) begin failures++; $display("[TB] FAIL aligned_locked: got %b expected 1", locked); end
      checks++; if (de !== 1'b0) begin failures++; $display("[TB] FAIL aligned_de: got %b expected 0", de); end
      checks++; if (ctrl !== 2'b00) begin failures++; $display("[TB] FAIL aligned_ctrl: got %b expected 00", ctrl); end
      checks++; if (dout !== 8'h00) begin failures++; $display("[TB] FAIL aligned_dout: got %h expected 00", dout); end
    end
  endtask

  task automatic test_token_map();
    logic [9:0] syms [3];
    logic [1:0] expCtrl [3];
    syms = '{10'h0AB, 10'h154, 10'h2AB};
    expCtrl = '{2'b01, 2'b10, 2'b11};
    for (int i = 0; i <= 3; i++) begin
      step((i < 3) ? syms[i] : 10'h2AB);
      if (i >= 1) begin
        checks++; if (ctrl !== expCtrl[i-1]) begin failures++; $display("[TB] FAIL token_ctrl[%0d]: got %b expected %b", i-1, ctrl, expCtrl[i-1]); end
        checks++; if (de !== 1'b0) begin failures++; $display("[TB] FAIL token_de[%0d]: got %b expected 0", i-1, de); end
        checks++; if (dout !== 8'h00) begin failures++; $display("[TB] FAIL token_dout[%0d]: got %h expected 00", i-1, dout); end
      end
    end
  endtask

  task automatic test_data_decode();
    logic [9:0] syms [3];
    logic [7:0] expByte [3];
    syms = '{10'h100, 10'h1FF, 10'h2FF};
    expByte = '{8'h00, 8'h01, 8'hFE};
    for (int i = 0; i <= 3; i++) begin
      step((i < 3) ? syms[i] : 10'h2FF);
      if (i >= 1) begin
        checks++; if (de !== 1'b1) begin failures++; $display("[TB] FAIL data_de[%0d]: got %b expected 1", i-1, de); end
        checks++; if (dout !== expByte[i-1]) begin failures++; $display("[TB] FAIL data_dout[%0d]: got %h expected %h", i-1, dout, expByte[i-1]); end
        checks++; if (ctrl !== 2'b11) begin failures++; $display("[TB] FAIL data_ctrl_hold[%0d]: got %b expected 11", i-1, ctrl); end
      end
    end
  endtask

  task automatic test_reset_locked();
    resetn = 1'b0;
    #1;
    checks++; if (locked !== 1'b0) begin failures++; $display("[TB] FAIL rst_locked_locked: got %b expected 0", locked); end
    checks++; if (de !== 1'b0) begin failures++; $display("[TB] FAIL rst_locked_de: got %b expected 0", de); end
    checks++; if (ctrl !== 2'b00) begin failures++; $display("[TB] FAIL rst_locked_ctrl: got %b expected 00", ctrl); end
    checks++; if (dout !== 8'h00) begin failures++; $display("[TB] FAIL rst_locked_dout: got %h expected 00", dout); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_confirm_break();
    logic [9:0] seq [14];
    doReset();
    for (int i = 0; i < 14; i++) seq[i] = (i == 5) ? 10'h100 : 10'h354;
    for (int i = 0; i < 14; i++) begin
      step(seq[i]);
      checks++; if (locked !== 1'b0) begin failures++; $display("[TB] FAIL break_early_lock step %0d: got %b expected 0", i, locked); end
      checks++; if (bitslip !== 1'b0) begin failures++; $display("[TB] FAIL break_bitslip step %0d: got %b expected 0", i, bitslip); end
    end
    step(10'h354);
    checks++; if (locked !== 1'b1) begin failures++; $display("[TB] FAIL break_relock: got %b expected 1", locked); end
  endtask

  task automatic test_loss();
    bit got;
    doReset();
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      step(10'h354);
      if (locked === 1'b1) got = 1'b1;
    end
    checks++; if (!got) begin failures++; $display("[TB] FAIL loss_initial_lock: got 0 expected 1"); end
    for (int k = 1; k <= 40; k++) begin
      step(10'h100);
      checks++;
      if (locked !== ((k <= LO) ? 1'b1 : 1'b0)) begin
        failures++; $display("[TB] FAIL loss_locked cycle %0d: got %b expected %b", k, locked, (k <= LO));
      end
      if (k >= 2 && k <= LO) begin
        checks++; if (de !== 1'b1) begin failures++; $display("[TB] FAIL loss_de_locked cycle %0d: got %b expected 1", k, de); end
      end
      if (k > LO) begin
        checks++;
        if (de !== 1'b0 || ctrl !== 2'b00 || dout !== 8'h00) begin
          failures++; $display("[TB] FAIL loss_outputs cycle %0d: got de=%b ctrl=%b dout=%h expected 0/00/00", k, de, ctrl, dout);
        end
      end
    end
  endtask

  task automatic test_misalign();
    int r, slips, lastSlip, cyc;
    bit prevSlip, done;
    doReset();
    r = 3; slips = 0; lastSlip = 0; prevSlip = 1'b0; done = 1'b0; cyc = 0;
    while (!done && cyc < 1500) begin
      cyc++;
      step(rotl10(10'h354, r));
      if (prevSlip) begin
        checks++; if (bitslip !== 1'b0) begin failures++; $display("[TB] FAIL misalign_pulse_width cycle %0d: got %b expected 0", cyc, bitslip); end
      end
      if (bitslip === 1'b1) begin
        slips++;
        if (slips > 1) begin
          checks++;
          if (cyc - lastSlip < ST + SW) begin
            failures++; $display("[TB] FAIL misalign_spacing: got %0d expected >= %0d", cyc - lastSlip, ST + SW);
          end
        end
        lastSlip = cyc;
        r = (r + 1) % 10;
      end
      prevSlip = (bitslip === 1'b1);
      if (locked === 1'b1) done = 1'b1;
    end
    checks++; if (!done) begin failures++; $display("[TB] FAIL misalign_lock_timeout: got locked=%b expected 1", locked); end
    checks++; if (slips != 7) begin failures++; $display("[TB] FAIL misalign_slip_count: got %0d expected 7", slips); end
    for (int k = 0; k < 3; k++) begin
      step(rotl10(10'h354, r));
      checks++;
      if (locked !== 1'b1 || ctrl !== 2'b00 || de !== 1'b0 || bitslip !== 1'b0) begin
        failures++; $display("[TB] FAIL misalign_post_lock: got locked=%b ctrl=%b de=%b bitslip=%b expected 1/00/0/0", locked, ctrl, de, bitslip);
      end
    end
  endtask

  task automatic test_reset_slip();
    bit seen;
    doReset();
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      step(10'h100);
      if (bitslip === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("[TB] FAIL rst_slip_pulse_seen: got 0 expected 1"); end
    resetn = 1'b0;
    #1;
    checks++; if (bitslip !== 1'b0) begin failures++; $display("[TB] FAIL rst_slip_bitslip: got %b expected 0", bitslip); end
    checks++;
    if (locked !== 1'b0 || de !== 1'b0 || ctrl !== 2'b00 || dout !== 8'h00) begin
      failures++; $display("[TB] FAIL rst_slip_outputs: got locked=%b de=%b ctrl=%b dout=%h expected 0/0/00/00", locked, de, ctrl, dout);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_token_map();
    test_data_decode();
    test_reset_locked();
    test_confirm_break();
    test_loss();
    test_misalign();
    test_reset_slip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
